// File: rtl/mem_req_arbiter_if.sv
// Request/response bus between requesters and a memory controller.
// N is the number of requester ports multiplexed onto the bus.
interface mem_req_arbiter_if #(
    parameter int N = 1
);
    logic [N*32-1:0]  req_addr;
    logic [N*128-1:0] req_dat;
    logic [N*4-1:0]   req_len;
    logic [N-1:0]     req_r_w;
    logic [N-1:0]     req_submit;
    logic [N-1:0]     req_acc;
    logic [31:0]      res_addr;
    logic [127:0]     res_dat;
    logic [3:0]       res_len;
    logic [N-1:0]     res_rdy;
    logic [N-1:0]     res_read;

    modport master (
        output req_addr, req_dat, req_len, req_r_w, req_submit, res_read,
        input  req_acc, res_addr, res_dat, res_len, res_rdy
    );

    modport slave (
        input  req_addr, req_dat, req_len, req_r_w, req_submit, res_read,
        output req_acc, res_addr, res_dat, res_len, res_rdy
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin two-port arbiter in front of a single memory controller, one
// transaction in flight, with a sticky watchdog on the ISSUE+WAIT span.
module mem_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst,
    mem_req_arbiter_if.slave    s,
    mem_req_arbiter_if.master   m,
    output logic                err_timeout
);
    localparam logic [CNT_W-1:0] LP_TMO    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LP_TMO_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_pri;
    logic               r_g;
    logic               r_first;
    logic [31:0]        r_addr;
    logic [127:0]       r_dat;
    logic [3:0]         r_len;
    logic               r_r_w;
    logic [31:0]        r_res_addr;
    logic [127:0]       r_res_dat;
    logic [3:0]         r_res_len;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic               w_grant;
    logic               w_go;

    // The priority port wins a tie; otherwise whichever port is asking.
    assign w_grant = s.req_submit[r_pri] ? r_pri : ~r_pri;
    assign w_go    = (r_state == IDLE) && (|s.req_submit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (|s.req_submit)      w_next_state = ISSUE;
            ISSUE:   if (m.req_acc[0])       w_next_state = WAIT;
            WAIT:    if (m.res_rdy[0])       w_next_state = DELIVER;
            DELIVER: if (s.res_read[r_g])    w_next_state = IDLE;
            default:                         w_next_state = IDLE;
        endcase
    end

    always_comb begin
        s.req_acc    = '0;
        s.res_rdy    = '0;
        m.req_submit = 1'b0;
        m.res_read   = 1'b0;
        if (r_state == ISSUE) begin
            m.req_submit = 1'b1;
            if (r_first) s.req_acc[r_g] = 1'b1;
        end
        if (r_state == WAIT)    m.res_read   = m.res_rdy[0];
        if (r_state == DELIVER) s.res_rdy[r_g] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pri      <= 1'b0;
            r_g        <= 1'b0;
            r_first    <= 1'b0;
            r_addr     <= '0;
            r_dat      <= '0;
            r_len      <= '0;
            r_r_w      <= 1'b0;
            r_res_addr <= '0;
            r_res_dat  <= '0;
            r_res_len  <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_first <= w_go;
            if (w_go) begin
                r_g    <= w_grant;
                r_addr <= w_grant ? s.req_addr[63:32]  : s.req_addr[31:0];
                r_dat  <= w_grant ? s.req_dat[255:128] : s.req_dat[127:0];
                r_len  <= w_grant ? s.req_len[7:4]     : s.req_len[3:0];
                r_r_w  <= w_grant ? s.req_r_w[1]       : s.req_r_w[0];
                r_cnt  <= '0;
            end
            // Watchdog saturates so err_timeout stays a clean level.
            if ((r_state == ISSUE) || (r_state == WAIT)) begin
                if (r_cnt != LP_TMO)    r_cnt <= r_cnt + 1'b1;
                if (r_cnt == LP_TMO_M1) r_err <= 1'b1;
            end
            if ((r_state == WAIT) && m.res_rdy[0]) begin
                r_res_addr <= m.res_addr;
                r_res_dat  <= m.res_dat;
                r_res_len  <= m.res_len;
            end
            if ((r_state == DELIVER) && s.res_read[r_g]) r_pri <= ~r_g;
        end
    end

    assign m.req_addr  = r_addr;
    assign m.req_dat   = r_dat;
    assign m.req_len   = r_len;
    assign m.req_r_w   = r_r_w;
    assign s.res_addr  = r_res_addr;
    assign s.res_dat   = r_res_dat;
    assign s.res_len   = r_res_len;
    assign err_timeout = r_err;
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Two-port arbiter sharing the single core memory access controller between instruction fetch (port 0) and load/store (port 1). It accepts one request at a time, forwards it downstream, and routes the response back to the originating port before accepting the next request. Arbitration is round-robin, and a watchdog flags stalled transactions. It sits between the core pipeline and the memory access controller.

## Interface
- TIMEOUT_CYCLES, 1024: watchdog limit, in cycles, for the ISSUE plus WAIT portion of a transaction.
- CNT_W, 16: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_req_addr  in  64  {p1,p0} request addresses, 32 bits each.
- s_req_dat  in  256  {p1,p0} write data, 128 bits each.
- s_req_len  in  8  {p1,p0} byte lengths, 4 bits each.
- s_req_r_w  in  2  per port: 1 = read, 0 = write.
- s_req_submit  in  2  per-port request valid.
- s_req_acc  out  2  per-port accept pulse.
- s_res_addr  out  32  response address, shared by both ports.
- s_res_dat  out  128  response data, shared by both ports.
- s_res_len  out  4  response length, shared by both ports.
- s_res_rdy  out  2  per-port response valid.
- s_res_read  in  2  per-port response consume.
- m_req_addr / m_req_dat / m_req_len / m_req_r_w  out  32/128/4/1  downstream request fields.
- m_req_submit  out  1  downstream request valid.
- m_req_acc  in  1  downstream accept.
- m_res_addr / m_res_dat / m_res_len  in  32/128/4  downstream response fields.
- m_res_rdy  in  1  downstream response valid.
- m_res_read  out  1  downstream response consume.
- err_timeout  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DELIVER. Reset enters IDLE.
- Priority pointer `pri` resets to 0.
- **IDLE:**
  - If any s_req_submit bit is high, grant g.
  - g = pri if s_req_submit[pri] is high; otherwise g = the other port.
  - Latch port g's addr, dat, len, r_w and g itself. Next state is ISSUE.
- **ISSUE:**
  - s_req_acc[g] = 1 in the first ISSUE cycle only.
  - m_req_submit = 1 with the latched fields, which stay stable throughout ISSUE.
  - When m_req_acc is sampled high, next state is WAIT.
- **WAIT:**
  - m_res_read = (state==WAIT && m_res_rdy). This is combinational, so it fires in the same cycle.
  - When m_res_rdy is high, capture m_res_addr, m_res_dat and m_res_len. Next state is DELIVER.
- **DELIVER:**
  - s_res_rdy[g] = 1, and s_res_* drive the captured values.
  - When s_res_read[g] is high: pri <= ~g, next state is IDLE.
- Write requests also receive exactly one downstream response, an acknowledgment. Its dat field is don't-care and is still delivered.
- s_res_read on the non-granted port is ignored.
- s_req_submit is ignored outside IDLE. Requesters hold submit and fields until they see acc.
- **Watchdog:**
  - Counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - It saturates at TIMEOUT_CYCLES.
  - When it reaches TIMEOUT_CYCLES, err_timeout is set and stays set until rst.
  - No change to FSM behaviour.

## Timing
- Reset values: all outputs 0, the s_res_*/m_req_* data buses 0, pri = 0, counter = 0, err_timeout = 0.
- Cycle N: IDLE samples submit. N+1: ISSUE, with s_req_acc pulsed and m_req_submit high.
- If m_req_acc is high at N+1: WAIT at N+2.
- If m_res_rdy is high at N+2: m_res_read is high at N+2, and DELIVER with s_res_rdy high at N+3.
- If s_res_read is high at N+3: IDLE at N+4.
- Minimum transaction latency is 4 cycles, submit to IDLE re-entry. Back-to-back grants are therefore spaced at least 4 cycles apart.
- Simultaneous submits in IDLE: pri wins. The loser stays pending and is granted in the next IDLE.
- Reset asserted mid-transaction: return to IDLE next cycle and drop all handshakes. The latched transaction is lost; the downstream controller is reset alongside.
- Watchdog: with continuous stall, err_timeout rises exactly TIMEOUT_CYCLES cycles after ISSUE entry.

## Test plan
- **Single read, port 0.** Stimulus: addr=0x0000_1000, len=4, m_req_acc and m_res_rdy given immediately. Required: acc at N+1; m_req_addr=0x1000 with m_req_r_w=1; s_res_rdy=2'b01 at N+3 carrying the m_res_dat value; IDLE at N+4.
- **Simultaneous submits from reset.** Required: port 0 granted first, then port 1. With both held continuously, the grants alternate 0,1,0,1.
- **Write, port 1, with downstream stalls.** Stimulus: addr=0xDEAD_BEE0, dat=128'hA5…A5, m_req_acc delayed 3 cycles, m_res_rdy delayed 5 cycles. Required: fields stable throughout ISSUE; m_res_read is a single-cycle pulse; s_res_rdy=2'b10.
- **Late consume.** Stimulus: hold s_res_read low for 7 cycles in DELIVER and assert s_res_read[0] while g=1. Required: no exit from DELIVER, and s_res_* stay stable throughout.
- **Watchdog.** Stimulus: TIMEOUT_CYCLES=8 with m_req_acc never asserted. Required: err_timeout rises 8 cycles after ISSUE entry and stays high until rst.
- **Reset mid-WAIT.** Required: next cycle is IDLE with all outputs 0, pri=0 and err_timeout=0; a new submit is accepted normally.
